// File: rtl/dig_pkg.sv
// Shared geometry, FSM encoding and helpers for the digger's tunnel map.
package dig_pkg;

    localparam int TILE_SHIFT   = 3;
    localparam int MAP_COLS     = 60;
    localparam int MAP_ROWS     = 40;
    localparam int SPRITE_TILES = 4;
    localparam int ROW_IDX_W    = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        REPORT = 2'd2,
        CLEAR  = 2'd3
    } dig_state_t;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

endpackage

// File: rtl/player_dig_trail_if.sv
// Bundle between the player mover / board renderer and the dig-trail recorder.
interface player_dig_trail_if;

    logic               startOfFrame;
    logic               clearBoard;
    logic signed [10:0] topLeftX;
    logic signed [10:0] topLeftY;
    logic               player_awake;
    logic        [10:0] pixelX;
    logic        [10:0] pixelY;
    logic               dugPixel;
    logic               digDone;
    logic        [4:0]  frameDugTiles;
    logic               busy;

    modport master (
        output startOfFrame, clearBoard, topLeftX, topLeftY, player_awake,
        output pixelX, pixelY,
        input  dugPixel, digDone, frameDugTiles, busy
    );

    modport slave (
        input  startOfFrame, clearBoard, topLeftX, topLeftY, player_awake,
        input  pixelX, pixelY,
        output dugPixel, digDone, frameDugTiles, busy
    );

endinterface

// File: rtl/dig_map_mem.sv
// Tile dig map: one 60-bit word per tile row, OR/clear write port returning the
// pre-write row, plus a registered single-bit read port for the renderer.
module dig_map_mem
    import dig_pkg::*;
(
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  wr_en,
    input  logic [ROW_IDX_W-1:0]  wr_row,
    input  logic [MAP_COLS-1:0]   wr_set,
    input  logic                  wr_clr,
    output logic [MAP_COLS-1:0]   wr_old,
    input  logic [ROW_IDX_W-1:0]  rd_row,
    input  logic [ROW_IDX_W-1:0]  rd_col,
    input  logic                  rd_valid,
    output logic                  rd_bit
);

    logic [MAP_COLS-1:0] rows_mem [MAP_ROWS];
    logic                rd_bit_reg;

    assign wr_old = rows_mem[wr_row];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            rows_mem[wr_row] <= wr_clr ? '0 : (wr_old | wr_set);
        end
    end

    // Nonblocking read of the same array means a same-cycle write is not yet visible.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rd_bit_reg <= 1'b0;
        end else begin
            rd_bit_reg <= rd_valid & rows_mem[rd_row][rd_col];
        end
    end

    assign rd_bit = rd_bit_reg;

endmodule

// File: rtl/player_dig_trail.sv
// Marks the 4x4 tiles under the player sprite as dug once per frame, reports the
// newly dug count, and serves a 1-cycle pixel lookup of the map to the renderer.
module player_dig_trail
    import dig_pkg::*;
#(
    parameter logic [10:0] board_position_X = 11'd32,
    parameter logic [10:0] board_position_Y = 11'd160
)(
    input  logic                clk,
    input  logic                resetN,
    player_dig_trail_if.slave   bus
);

    localparam logic signed [11:0] COL_LIM = 12'(MAP_COLS);
    localparam logic signed [11:0] ROW_LIM = 12'(MAP_ROWS);
    localparam logic        [11:0] PIX_W   = 12'(MAP_COLS << TILE_SHIFT);
    localparam logic        [11:0] PIX_H   = 12'(MAP_ROWS << TILE_SHIFT);

    dig_state_t             state_reg, state_next;
    logic [1:0]             k_reg, k_next;
    logic [ROW_IDX_W-1:0]   clr_row_reg, clr_row_next;
    logic signed [11:0]     c0_reg, c0_next, r0_reg, r0_next;
    logic [4:0]             sum_reg, sum_next;
    logic                   done_reg, done_next;
    logic [4:0]             tiles_reg, tiles_next;

    logic signed [11:0]     rel_x, rel_y, c0_in, r0_in;
    logic signed [11:0]     row_s;
    logic                   row_ok;
    logic [MAP_COLS-1:0]    tile_mask [SPRITE_TILES];
    logic [SPRITE_TILES-1:0] tile_new;
    logic [MAP_COLS-1:0]    set_mask;
    logic [2:0]             newly;

    logic                   wr_en, wr_clr;
    logic [ROW_IDX_W-1:0]   wr_row;
    logic [MAP_COLS-1:0]    wr_old;
    logic [11:0]            dx, dy;
    logic                   rd_valid, rd_bit;

    // Sprite anchor rounded to the nearest tile, taken from the pre-move position.
    assign rel_x = signed'({bus.topLeftX[10], bus.topLeftX}) - signed'({1'b0, board_position_X});
    assign rel_y = signed'({bus.topLeftY[10], bus.topLeftY}) - signed'({1'b0, board_position_Y});
    assign c0_in = (rel_x + 12'sd4) >>> TILE_SHIFT;
    assign r0_in = (rel_y + 12'sd4) >>> TILE_SHIFT;

    assign row_s  = r0_reg + signed'({10'd0, k_reg});
    assign row_ok = (row_s >= 12'sd0) && (row_s < ROW_LIM);

    for (genvar gi = 0; gi < SPRITE_TILES; gi++) begin : g_tile
        logic signed [11:0]   col_s;
        logic                 col_ok;
        logic [ROW_IDX_W-1:0] col_idx;

        assign col_s          = c0_reg + signed'(12'(gi));
        assign col_ok         = (col_s >= 12'sd0) && (col_s < COL_LIM);
        assign col_idx        = col_s[ROW_IDX_W-1:0];
        assign tile_mask[gi]  = col_ok ? (MAP_COLS'(1) << col_idx) : '0;
        assign tile_new[gi]   = col_ok && row_ok && !wr_old[col_idx];
    end

    always_comb begin
        set_mask = '0;
        for (int i = 0; i < SPRITE_TILES; i++) begin
            set_mask = set_mask | tile_mask[i];
        end
    end

    assign newly = popcount4(tile_new);

    always_comb begin
        wr_en  = 1'b0;
        wr_clr = 1'b0;
        wr_row = row_s[ROW_IDX_W-1:0];
        case (state_reg)
            WRITE: wr_en = row_ok && !bus.clearBoard;
            CLEAR: begin
                wr_en  = 1'b1;
                wr_clr = 1'b1;
                wr_row = clr_row_reg;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next   = state_reg;
        k_next       = k_reg;
        clr_row_next = clr_row_reg;
        c0_next      = c0_reg;
        r0_next      = r0_reg;
        sum_next     = sum_reg;
        done_next    = 1'b0;
        tiles_next   = tiles_reg;
        case (state_reg)
            IDLE: begin
                if (bus.clearBoard) begin
                    state_next   = CLEAR;
                    clr_row_next = '0;
                end else if (bus.startOfFrame && bus.player_awake) begin
                    state_next = WRITE;
                    k_next     = 2'd0;
                    sum_next   = 5'd0;
                    c0_next    = c0_in;
                    r0_next    = r0_in;
                end
            end
            WRITE: begin
                if (bus.clearBoard) begin
                    state_next   = CLEAR;
                    clr_row_next = '0;
                end else begin
                    sum_next = sum_reg + {2'b00, newly};
                    k_next   = k_reg + 2'd1;
                    if (k_reg == 2'd3) begin
                        state_next = REPORT;
                    end
                end
            end
            REPORT: begin
                if (bus.clearBoard) begin
                    state_next   = CLEAR;
                    clr_row_next = '0;
                end else begin
                    done_next  = 1'b1;
                    tiles_next = sum_reg;
                    state_next = IDLE;
                end
            end
            CLEAR: begin
                if (bus.clearBoard) begin
                    clr_row_next = '0;
                end else if (clr_row_reg == ROW_IDX_W'(MAP_ROWS - 1)) begin
                    state_next = IDLE;
                end else begin
                    clr_row_next = clr_row_reg + 1'b1;
                end
            end
            default: state_next = CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_reg   <= CLEAR;
            k_reg       <= 2'd0;
            clr_row_reg <= '0;
            c0_reg      <= '0;
            r0_reg      <= '0;
            sum_reg     <= '0;
            done_reg    <= 1'b0;
            tiles_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            k_reg       <= k_next;
            clr_row_reg <= clr_row_next;
            c0_reg      <= c0_next;
            r0_reg      <= r0_next;
            sum_reg     <= sum_next;
            done_reg    <= done_next;
            tiles_reg   <= tiles_next;
        end
    end

    // Unsigned wrap makes pixels left of / above the board fail the range test.
    assign dx       = {1'b0, bus.pixelX} - {1'b0, board_position_X};
    assign dy       = {1'b0, bus.pixelY} - {1'b0, board_position_Y};
    assign rd_valid = (dx < PIX_W) && (dy < PIX_H) && (state_reg != CLEAR);

    dig_map_mem u_map (
        .clk      (clk),
        .resetN   (resetN),
        .wr_en    (wr_en),
        .wr_row   (wr_row),
        .wr_set   (set_mask),
        .wr_clr   (wr_clr),
        .wr_old   (wr_old),
        .rd_row   (dy[TILE_SHIFT +: ROW_IDX_W]),
        .rd_col   (dx[TILE_SHIFT +: ROW_IDX_W]),
        .rd_valid (rd_valid),
        .rd_bit   (rd_bit)
    );

    assign bus.dugPixel      = rd_bit;
    assign bus.digDone       = done_reg;
    assign bus.frameDugTiles = tiles_reg;
    assign bus.busy          = (state_reg != IDLE);

endmodule
